// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - synchronize, debounce and settle panel switches
//
// Purpose: turns raw, bouncing panel switches into a clean vector that
// changes once per user action, with a one-cycle change pulse and a decoded
// selection status registered alongside the published vector.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   switch_raw   raw switches, asynchronous to clk, 1 = on
//   switch_out   published switch vector (registered)
//   change_pulse one-cycle pulse when switch_out takes a new value
//   multi_err    high while more than one bit of switch_out is set
//   sel_code     0 = none set, k+1 = only bit k set, 15 = multiple set
module switch_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int SETTLE_CYCLES   = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_out,
    output logic             change_pulse,
    output logic             multi_err,
    output logic [3:0]       sel_code
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int SCNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic {IDLE, SETTLE} state_t;

    logic [WIDTH-1:0]            s1_q, s2_q;
    logic [WIDTH-1:0]            stable_q, stable_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    state_t                      state_q, state_d;
    logic [WIDTH-1:0]            cand_q, cand_d;
    logic [SCNT_W-1:0]           scnt_q, scnt_d;
    logic                        publish;

    logic [WIDTH-1:0]            out_q, out_d;
    logic                        pulse_q, pulse_d;
    logic                        multi_q, multi_d;
    logic [3:0]                  sel_q, sel_d;

    logic                        dec_seen;
    logic                        dec_multi;
    logic [3:0]                  dec_sel;

    // Per-bit debounce: a bit flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= switch_raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Settle FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            scnt_q  <= scnt_d;
        end
    end

    // Settle FSM: next state. Any movement of the debounced vector restarts
    // the window, so staggered multi-switch changes publish only once.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        scnt_d  = scnt_q;
        publish = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable_q != out_q) begin
                    cand_d  = stable_q;
                    scnt_d  = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (stable_q != cand_q) begin
                    cand_d = stable_q;
                    scnt_d = '0;
                end else if (scnt_q == SCNT_LAST) begin
                    state_d = IDLE;
                    // A bounce back to the old value ends silently.
                    publish = (cand_q != out_q);
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Selection decode of the candidate, so status lands with switch_out.
    always_comb begin
        dec_seen  = 1'b0;
        dec_multi = 1'b0;
        dec_sel   = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cand_q[i]) begin
                if (dec_seen) begin
                    dec_multi = 1'b1;
                end
                dec_seen = 1'b1;
                dec_sel  = 4'(i + 1);
            end
        end
        if (dec_multi) begin
            dec_sel = 4'd15;
        end
    end

    // Settle FSM: outputs
    always_comb begin
        out_d   = out_q;
        pulse_d = 1'b0;
        multi_d = multi_q;
        sel_d   = sel_q;
        if (publish) begin
            out_d   = cand_q;
            pulse_d = 1'b1;
            multi_d = dec_multi;
            sel_d   = dec_sel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            pulse_q <= 1'b0;
            multi_q <= 1'b0;
            sel_q   <= 4'd0;
        end else begin
            out_q   <= out_d;
            pulse_q <= pulse_d;
            multi_q <= multi_d;
            sel_q   <= sel_d;
        end
    end

    assign switch_out   = out_q;
    assign change_pulse = pulse_q;
    assign multi_err    = multi_q;
    assign sel_code     = sel_q;

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Front-end stage that drives the 8-bit switch vector into the LED-matrix message selector/scroller.
- Takes raw panel switches and produces a synchronized, debounced, glitch-free vector that changes only once per user action.
- Also produces a one-cycle change pulse, which the scroller uses as its restart request, plus decoded selection status.
- Runs on the same 1 kHz system clock as the display logic.

Parameters:
- WIDTH, 8, number of panel switches.
- DEBOUNCE_CYCLES, 20, consecutive clk cycles a raw bit must differ from its stable value before it flips (20 ms at 1 kHz); minimum 2.
- SETTLE_CYCLES, 50, clk cycles the whole debounced vector must hold before it is published; absorbs staggered multi-switch transitions; minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- switch_raw  input  WIDTH  raw panel switches, asynchronous to clk, 1 = on.
- switch_out  output  WIDTH  published switch vector, registered.
- change_pulse  output  1  high for exactly one cycle when switch_out takes a new value.
- multi_err  output  1  high while more than one bit of switch_out is set.
- sel_code  output  4  decoded selection: 0 = none set; k+1 = only bit k set; 15 = multiple bits set.

Behaviour:
- Reset (reset=0, async): clears sync flops, stable bits, per-bit counters, settle counter and candidate; FSM goes to IDLE.
  - All outputs are 0 during reset.
  - No change_pulse is generated on reset release.
- Sync: 2-flop synchronizer per bit (s1, then s2).
- Debounce, per bit, independent:
  - If s2 != stable: cnt increments; on the edge where cnt == DEBOUNCE_CYCLES-1, stable <= s2 and cnt <= 0.
  - If s2 == stable: cnt <= 0. Any bounce restarts the count.
  - cnt width is clog2(DEBOUNCE_CYCLES); it never wraps.
- Settle FSM, states IDLE and SETTLE, operating on the debounced vector deb:
  - IDLE: if deb != switch_out, then candidate <= deb, scnt <= 0, go to SETTLE. Otherwise stay.
  - SETTLE, deb != candidate: candidate <= deb, scnt <= 0, stay in SETTLE.
  - SETTLE, deb == candidate, scnt < SETTLE_CYCLES-1: scnt increments.
  - SETTLE, deb == candidate, scnt == SETTLE_CYCLES-1:
    - If candidate != switch_out: switch_out <= candidate, change_pulse <= 1.
    - Either way, return to IDLE.
  - If candidate equals switch_out at publish (a bounce back to the old value), no update and no pulse.
- Outputs:
  - multi_err and sel_code are registered on the same edge as switch_out; they are always consistent with switch_out.
  - change_pulse deasserts on the following edge.
- Latency: a raw change present before sampling edge 0 and held steady appears on switch_out at edge DEBOUNCE_CYCLES+SETTLE_CYCLES+2. With D=4, S=3 that is edge 9:
  - sync at edges 0-1;
  - stable flips at edge 5;
  - SETTLE entered at edge 6;
  - publish at edge 9.
- Boundary conditions:
  - Two switches changing within one settle window produce a single publish and a single pulse.
  - An all-off vector is a legal publish (sel_code=0).
  - A raw pulse shorter than DEBOUNCE_CYCLES has no effect.
  - Reset asserted mid-SETTLE aborts the transition. After release with switches still held, the normal full latency applies again and a pulse is produced.
  - switch_raw is ignored while reset is low.

Test Plan:
- Test parameters: D=4, S=3 throughout.
- Single switch: switch_raw 0x00→0x80 held → switch_out=0x80 at edge 9, change_pulse=1 for one cycle, sel_code=8, multi_err=0.
- Glitch rejection: switch_raw=0x01 for 3 cycles then 0x00 → switch_out stays 0x00, no pulse. Bounce 0x01/0x00 alternating for 10 cycles, then 0x01 held → publish 9 edges after the final transition.
- Staggered pair: 0x00→0x10, then 0x10→0x18 two cycles later → one pulse only; switch_out=0x18, multi_err=1, sel_code=15; never 0x10 on switch_out.
- Release: from published 0x04, raw→0x00 → switch_out=0x00, sel_code=0, one pulse. Repeat 0x04→0x00→0x04 within the settle window → no publish, no pulse.
- Reset mid-SETTLE: raw=0x02 and assert reset at edge 7 → all outputs 0 immediately. Release with raw still 0x02 → publish 9 edges after release; pulse seen once.
- Exhaustive singles: each one-hot value bit k → sel_code=k+1; 0xFF → sel_code=15, multi_err=1.
